iic_cmd_arbiter: RTL
====================

IIC_CMD_ARBITER -- requirements
Module: iic_cmd_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter RETRY_MAX, default 3: number of re-issues of a command after an err from the driver.
REQ-003 Parameter BUSY_TMO, default 4095: watchdog limit in clk_i cycles for each busy phase.
REQ-004 Port clk_i  input  1  the I2C bit-rate clock; all logic is on its rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port req_vld  input  2  command request per requester; bit 0 is the init table, bit 1 is the manual/VIO source.
REQ-007 Port req_rdy  output  2  one-cycle acceptance pulse per requester.
REQ-008 Port req_wr_rd  input  2  per-requester direction; 0 is write, 1 is read.
REQ-009 Port req_dev  input  16  per-requester 8-bit device address; requester n uses bits [8n+7:8n].
REQ-010 Port req_reg  input  32  per-requester 16-bit register address; requester n uses bits [16n+15:16n].
REQ-011 Port req_data  input  16  per-requester write byte; requester n uses bits [8n+7:8n].
REQ-012 Port rsp_vld  output  2  one-cycle completion pulse to the owning requester.
REQ-013 Port rsp_err  output  1  failure flag; valid only with rsp_vld.
REQ-014 Port rsp_data  output  8  read byte; valid only with rsp_vld.
REQ-015 Ports start_en (output, 1), wr_rd_flag (output, 1), i2c_device_addr (output, 8), register (output, 16) and data_byte (output, 8) SHALL drive the iic_drive command inputs.
REQ-016 Ports busy (input, 1), err (input, 1) and rd_data (input, 8) SHALL be the iic_drive status inputs.

Function
REQ-017 The FSM SHALL have these states: IDLE, LAUNCH, WAIT_HI, WAIT_LO, CHECK, RESP.
REQ-018 In IDLE with any req_vld set, the block SHALL grant one requester, pulse its req_rdy, latch that requester's command into the driver-facing registers, and enter LAUNCH on the next cycle.
REQ-019 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins; after reset, requester 0 wins.
REQ-020 LAUNCH SHALL assert start_en for exactly one cycle and then enter WAIT_HI.
REQ-021 WAIT_HI SHALL wait for busy=1 and then enter WAIT_LO; WAIT_LO SHALL wait for busy=0 and then enter CHECK.
REQ-022 CHECK SHALL sample err and rd_data; if err=1 and the retry count is below RETRY_MAX, it SHALL increment the count and return to LAUNCH; otherwise it SHALL enter RESP.
REQ-023 RESP SHALL pulse the granted requester's rsp_vld bit for one cycle, with rsp_err = the final err and rsp_data = the latched rd_data, then return to IDLE.
REQ-024 Latency SHALL be: req_rdy on the IDLE cycle, start_en one cycle later, rsp_vld one cycle after CHECK.
REQ-025 i2c_device_addr, register, data_byte and wr_rd_flag SHALL stay stable from LAUNCH through RESP.
REQ-026 req_vld SHALL be ignored outside IDLE; a requester may drop req_vld before req_rdy without side effect.
REQ-027 If busy is already 1 in IDLE, the block SHALL NOT grant.
REQ-028 The retry counter SHALL be $clog2(RETRY_MAX+1) bits wide and SHALL clear on each grant.
REQ-029 With RETRY_MAX=0, a first err SHALL go directly to RESP.
REQ-030 rsp_data SHALL be 0 for write commands.

Reset
REQ-031 When rst=1, the FSM SHALL go to IDLE and the round-robin pointer SHALL favour requester 0.
REQ-032 When rst=1, req_rdy, rsp_vld, start_en, rsp_err, wr_rd_flag, i2c_device_addr, register, data_byte, rsp_data and the retry count SHALL all be 0.
REQ-033 Reset in the middle of a command SHALL abandon it with no rsp_vld.

Configuration
REQ-034 With macro IIC_ARB_WATCHDOG_EN defined, a cycle counter SHALL run in WAIT_HI and WAIT_LO; reaching BUSY_TMO SHALL force RESP with rsp_err=1, and no retry.
REQ-035 Without IIC_ARB_WATCHDOG_EN, WAIT_HI and WAIT_LO SHALL wait indefinitely and BUSY_TMO SHALL be unused.

Structure
REQ-036 Package iic_pkg SHALL hold the FSM state enum, the WR=0/RD=1 constants and the requester-index constants.
REQ-037 Round-robin grant logic SHALL be the sub-module iic_rr_arb2: 2 requests, last-grant pointer, one-hot grant.

Verification
REQ-038 Requester 0 write: dev 0x6C, reg 0x3107, data 0x5A, driver busy 20 cycles, err=0 -> one start_en, stable outputs, rsp_vld=2'b01, rsp_err=0.
REQ-039 Both requesters valid in the same cycle, three times -> grants alternate 0, 1, 0.
REQ-040 Read with err=1 on the first two attempts, then rd_data=0xA5 -> 3 start_en pulses, rsp_err=0, rsp_data=0xA5.
REQ-041 err=1 on every attempt with RETRY_MAX=3 -> 4 start_en pulses, rsp_err=1.
REQ-042 With IIC_ARB_WATCHDOG_EN defined and busy never rising, BUSY_TMO=15 -> rsp_vld with rsp_err=1 16 cycles after start_en.
REQ-043 rst=1 asserted during WAIT_LO -> no rsp_vld; all outputs 0 on the next cycle; the next grant goes to requester 0.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C command arbiter.
// Optional busy watchdog is enabled with IIC_ARB_WATCHDOG_EN.
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    CHECK,
    RESP
  } state_t;

  localparam logic WR = 1'b0;
  localparam logic RD = 1'b1;

  localparam int NREQ     = 2;
  localparam int REQ_INIT = 0;
  localparam int REQ_MAN  = 1;

  // Round-robin pick: on contention the requester not granted last wins.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] req,
    input logic       last
  );
    logic [1:0] g;
    g = 2'b00;
    unique case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/iic_rr_arb2.sv
// Two-way round-robin arbiter with one-hot grant.
// Pointer remembers the last winner; reset favours requester 0.
module iic_rr_arb2
  import iic_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic r_last;
  logic [1:0] w_gnt;

  assign w_gnt = rr_pick(i_req, r_last);
  assign o_gnt = w_gnt;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_adv && (|w_gnt)) begin
      r_last <= w_gnt[REQ_MAN];
    end
  end

endmodule

// File: rtl/iic_cmd_arbiter.sv
// Arbitrates two command sources onto one iic_drive, with retry on err.
// Define IIC_ARB_WATCHDOG_EN to bound each busy phase by BUSY_TMO cycles.
module iic_cmd_arbiter
  import iic_pkg::*;
#(
  parameter int RETRY_MAX = 3,
  parameter int BUSY_TMO  = 4095
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [1:0]  req_vld,
  output logic [1:0]  req_rdy,
  input  logic [1:0]  req_wr_rd,
  input  logic [15:0] req_dev,
  input  logic [31:0] req_reg,
  input  logic [15:0] req_data,
  output logic [1:0]  rsp_vld,
  output logic        rsp_err,
  output logic [7:0]  rsp_data,
  output logic        start_en,
  output logic        wr_rd_flag,
  output logic [7:0]  i2c_device_addr,
  output logic [15:0] register,
  output logic [7:0]  data_byte,
  input  logic        busy,
  input  logic        err,
  input  logic [7:0]  rd_data
);

  localparam int RW =
    (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  state_t r_state;

  logic [1:0]    r_own;
  logic [RW-1:0] r_retry;
  logic          r_start;
  logic [1:0]    r_rsp_vld;
  logic          r_rsp_err;
  logic [7:0]    r_rsp_data;
  logic          r_wr_rd;
  logic [7:0]    r_dev;
  logic [15:0]   r_reg;
  logic [7:0]    r_data;

  logic [1:0]  w_gnt;
  logic        w_open;
  logic        w_take;
  logic        w_sel;
  logic        w_wr_rd;
  logic [7:0]  w_dev;
  logic [15:0] w_reg;
  logic [7:0]  w_data;
  logic        w_tmo;

  // Grant only from IDLE, and never while the driver is still busy.
  assign w_open = (r_state == IDLE) && !busy && !rst;
  assign w_take = w_open && (|w_gnt);

  iic_rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst   (rst),
    .i_req (req_vld),
    .i_adv (w_take),
    .o_gnt (w_gnt)
  );

  assign req_rdy = w_open ? w_gnt : 2'b00;

  assign w_sel   = w_gnt[REQ_MAN];
  assign w_wr_rd = w_sel ? req_wr_rd[1] : req_wr_rd[0];
  assign w_dev   = w_sel ? req_dev[15:8] : req_dev[7:0];
  assign w_reg   = w_sel ? req_reg[31:16] : req_reg[15:0];
  assign w_data  = w_sel ? req_data[15:8] : req_data[7:0];

`ifdef IIC_ARB_WATCHDOG_EN
  localparam int TW =
    (BUSY_TMO > 1) ? $clog2(BUSY_TMO + 1) : 1;

  logic [TW-1:0] r_wdog;
  logic          w_wait;

  assign w_wait = (r_state == WAIT_HI) ||
                  (r_state == WAIT_LO);
  assign w_tmo  = w_wait &&
                  (r_wdog == TW'(BUSY_TMO - 1));

  // Restarts for each busy phase.
  always_ff @(posedge clk_i) begin
    if (rst || !w_wait ||
        ((r_state == WAIT_HI) && busy)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (BUSY_TMO != 0);
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state    <= IDLE;
      r_own      <= 2'b00;
      r_retry    <= '0;
      r_start    <= 1'b0;
      r_rsp_vld  <= 2'b00;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= 8'h00;
      r_wr_rd    <= WR;
      r_dev      <= 8'h00;
      r_reg      <= 16'h0000;
      r_data     <= 8'h00;
    end else begin
      r_start   <= 1'b0;
      r_rsp_vld <= 2'b00;
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            r_own   <= w_gnt;
            r_retry <= '0;
            r_wr_rd <= w_wr_rd;
            r_dev   <= w_dev;
            r_reg   <= w_reg;
            r_data  <= w_data;
            r_start <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (busy) begin
            r_state <= WAIT_LO;
          end else if (w_tmo) begin
            r_rsp_vld  <= r_own;
            r_rsp_err  <= 1'b1;
            r_rsp_data <= 8'h00;
            r_state    <= RESP;
          end
        end
        WAIT_LO: begin
          if (!busy) begin
            r_state <= CHECK;
          end else if (w_tmo) begin
            r_rsp_vld  <= r_own;
            r_rsp_err  <= 1'b1;
            r_rsp_data <= 8'h00;
            r_state    <= RESP;
          end
        end
        CHECK: begin
          if (err && (r_retry < RMAX)) begin
            r_retry <= r_retry + 1'b1;
            r_start <= 1'b1;
            r_state <= LAUNCH;
          end else begin
            r_rsp_vld  <= r_own;
            r_rsp_err  <= err;
            r_rsp_data <= (r_wr_rd == RD) ? rd_data : 8'h00;
            r_state    <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign start_en        = r_start;
  assign rsp_vld         = r_rsp_vld;
  assign rsp_err         = r_rsp_err;
  assign rsp_data        = r_rsp_data;
  assign wr_rd_flag      = r_wr_rd;
  assign i2c_device_addr = r_dev;
  assign register        = r_reg;
  assign data_byte       = r_data;

endmodule
